// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/response plus the
// valid/ready handshake toward decode.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch requester for a synchronous-read memory, with a one-entry
// skid buffer toward decode. Optional perf counters: define IFU_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1),
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_en,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  instr_fetch_unit_if.master  bus
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              rsp_v_q, rsp_v_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;

  logic issue;
  logic capture;
  logic release_skid;
  logic xfer;

  assign bus.imem_addr = pc_q;

  // Skid entry is always older than a live response, so it is presented first.
  always_comb begin
    bus.if_valid = 1'b0;
    bus.if_instr = '0;
    bus.if_pc    = '0;
    if (skid_v_q) begin
      bus.if_valid = !redirect;
      bus.if_instr = skid_instr_q;
      bus.if_pc    = skid_pc_q;
    end else if (rsp_v_q) begin
      bus.if_valid = !redirect;
      bus.if_instr = bus.imem_data;
      bus.if_pc    = rsp_pc_q;
    end
  end

  always_comb begin
    xfer         = bus.if_valid && bus.if_ready;
    issue        = !redirect && fetch_en && !skid_v_q && !(rsp_v_q && !bus.if_ready);
    capture      = !redirect && rsp_v_q && !skid_v_q && !bus.if_ready;
    release_skid = !redirect && skid_v_q && bus.if_ready;
  end

  always_comb begin
    pc_d         = pc_q;
    rsp_v_d      = 1'b0;
    rsp_pc_d     = rsp_pc_q;
    skid_v_d     = skid_v_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (redirect) begin
      pc_d     = redirect_pc;
      skid_v_d = 1'b0;
    end else begin
      if (issue) begin
        rsp_v_d  = 1'b1;
        rsp_pc_d = pc_q;
        pc_d     = pc_q + PC_STEP;
      end
      if (capture) begin
        skid_v_d     = 1'b1;
        skid_instr_d = bus.imem_data;
        skid_pc_d    = rsp_pc_q;
      end else if (release_skid) begin
        skid_v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      rsp_v_q      <= 1'b0;
      rsp_pc_q     <= '0;
      skid_v_q     <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      rsp_v_q      <= rsp_v_d;
      rsp_pc_q     <= rsp_pc_d;
      skid_v_q     <= skid_v_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  // A capture can also occur while idle, when fetch_en drops with a response
  // still in flight, so STALL is entered from either non-stall state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (capture)       state_d = STALL;
        else if (fetch_en) state_d = RUN;
      end
      RUN: begin
        if (capture)        state_d = STALL;
        else if (!fetch_en) state_d = IDLE;
      end
      STALL: begin
        if (redirect || release_skid) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (xfer && (fetch_cnt_q != '1))
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (bus.if_valid && !bus.if_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  logic unused_xfer;
  assign unused_xfer = xfer;
`endif

endmodule
